alu_mismatch_monitor: RTL and testbench



---
 rtl/alu_mismatch_monitor.sv | 119 +++++++++++
 tb/tb_alu_mismatch_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mismatch_monitor.sv
// Dual-ALU compare-stage monitor: counts samples and mismatches, captures the first syndrome,
// and trips a registered fault. Define ALU_MISMATCH_MON_CONSEC_EN to trip on consecutive mismatches.
module alu_mismatch_monitor #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             chk_valid,
  input  logic [3:0]       x,
  input  logic             y,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sticky_err,
  output logic [4:0]       first_syn,
  output logic             fault,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_d, err_cnt_d, trip_d;
  logic             sticky_d;
  logic [4:0]       syn_d;
  logic             mismatch, accept;

  // Handshake: chk_valid qualifies x/y for one cycle and there is no ready; every valid
  // sample seen in RUN with en=1 and clr=0 is consumed that cycle, anything else is dropped.
  assign mismatch = (|x) | y;
  assign accept   = chk_valid & (state_q == RUN) & en & ~clr;

`ifdef ALU_MISMATCH_MON_CONSEC_EN
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (clr) begin
      run_cnt_d = '0;
    end else if (accept) begin
      if (!mismatch)                run_cnt_d = '0;
      else if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) run_cnt_q <= '0;
    else           run_cnt_q <= run_cnt_d;
  end

  assign trip_d = run_cnt_d;
`else
  assign trip_d = err_cnt_d;
`endif

  always_comb begin
    sample_cnt_d = sample_cnt;
    err_cnt_d    = err_cnt;
    sticky_d     = sticky_err;
    syn_d        = first_syn;
    if (clr) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sticky_d     = 1'b0;
      syn_d        = '0;
    end else if (accept) begin
      if (sample_cnt != CNT_MAX) sample_cnt_d = sample_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt_d = err_cnt + 1'b1;
        sticky_d = 1'b1;
        if (!sticky_err) syn_d = {y, x};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en && !clr) state_d = RUN;
      RUN: begin
        if (clr)           state_d = en ? RUN : IDLE;
        else if (!en)      state_d = IDLE;
        else if (accept && mismatch && (trip_d >= THRESH_C)) state_d = FAULT;
      end
      FAULT: if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
      first_syn  <= '0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_cnt <= sample_cnt_d;
      err_cnt    <= err_cnt_d;
      sticky_err <= sticky_d;
      first_syn  <= syn_d;
      fault      <= (state_d == FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_mismatch_monitor.sv
// Directed bench for alu_mismatch_monitor; expectations follow the build selected by
// ALU_MISMATCH_MON_CONSEC_EN. A second instance (CNT_W=4, THRESH=15) covers saturation.
module tb_alu_mismatch_monitor;

`ifdef ALU_MISMATCH_MON_CONSEC_EN
  localparam bit CONSEC = 1'b1;
`else
  localparam bit CONSEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, chk_valid, y;
  logic [3:0] x;
  logic [7:0] sample_cnt, err_cnt;
  logic       sticky_err, fault;
  logic [4:0] first_syn;
  logic [1:0] state;

  logic       en_s, valid_s;
  logic [3:0] sample_cnt_s, err_cnt_s;
  logic       sticky_s, fault_s;
  logic [4:0] syn_s;
  logic [1:0] state_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mismatch_monitor dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .en(en), .clr(clr), .chk_valid(chk_valid),
    .x(x), .y(y), .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sticky_err(sticky_err),
    .first_syn(first_syn), .fault(fault), .state(state)
  );

  alu_mismatch_monitor #(.CNT_W(4), .THRESH(15)) dut_sat (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .en(en_s), .clr(1'b0), .chk_valid(valid_s),
    .x(4'h0), .y(1'b0), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s), .sticky_err(sticky_s),
    .first_syn(syn_s), .fault(fault_s), .state(state_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] vx, input logic vy);
    chk_valid = 1'b1;
    x = vx;
    y = vy;
    step();
    chk_valid = 1'b0;
    x = 4'h0;
    y = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"}, sample_cnt, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_sticky"}, sticky_err, 0);
    check({tag, "_syn"}, first_syn, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_state"}, state, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; chk_valid = 1'b0; x = 4'h0; y = 1'b0;
    en_s = 1'b0; valid_s = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Build up err_cnt=3 in RUN, then pulse reset between edges.
    en = 1'b1;
    step();
    check("enter_run", state, 2'b01);
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h0, 1'b1);
    check("pre_rst_err", err_cnt, 3);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2 rst_n = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 10; i++) send(4'hF, 1'b1);
    check("idle_sample", sample_cnt, 0);
    check("idle_err", err_cnt, 0);
    check("idle_state", state, 2'b00);

    // Clean stream.
    en = 1'b1;
    step();
    for (int i = 0; i < 20; i++) send(4'h0, 1'b0);
    check("clean_sample", sample_cnt, 20);
    check("clean_err", err_cnt, 0);
    check("clean_sticky", sticky_err, 0);
    check("clean_state", state, 2'b01);

    // Four mismatches separated by clean samples.
    send(4'b0110, 1'b0);
    check("first_syn_load", first_syn, 5'b00110);
    check("first_sticky", sticky_err, 1);
    send(4'h0, 1'b0);
    send(4'b0000, 1'b1);
    send(4'h0, 1'b0);
    send(4'b0001, 1'b0);
    send(4'h0, 1'b0);
    check("pre_trip_fault", fault, 0);
    send(4'b1000, 1'b0);
    check("trip_err", err_cnt, 4);
    check("trip_sample", sample_cnt, 27);
    check("trip_fault", fault, CONSEC ? 0 : 1);
    check("trip_state", state, CONSEC ? 2'b01 : 2'b10);
    check("syn_held", first_syn, 5'b00110);

    // Cumulative: frozen in FAULT. Consecutive: run of 1 plus 3 more trips.
    send(4'hF, 1'b1); send(4'h3, 1'b0); send(4'h0, 1'b1);
    check("post_err", err_cnt, CONSEC ? 7 : 4);
    check("post_sample", sample_cnt, CONSEC ? 30 : 27);
    check("post_fault", fault, 1);
    en = 1'b0;
    step();
    check("fault_ignores_en", state, 2'b10);
    en = 1'b1;

    // Clear wins over a valid mismatch in FAULT.
    clr = 1'b1;
    send(4'hF, 1'b1);
    clr = 1'b0;
    check_all_zero("clr_fault");

    // IDLE -> RUN, then en drop with a sample in the same cycle.
    step();
    check("rerun_state", state, 2'b01);
    en = 1'b0;
    send(4'h5, 1'b0);
    check("drop_state", state, 2'b00);
    check("drop_sample", sample_cnt, 0);
    en = 1'b1;
    step();

    // Clear in RUN with en=1 stays in RUN and discards the sample.
    send(4'h0, 1'b0);
    clr = 1'b1;
    send(4'h7, 1'b0);
    clr = 1'b0;
    check("clr_run_state", state, 2'b01);
    check("clr_run_sample", sample_cnt, 0);

    // Pattern m m m c m m m m.
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h4, 1'b0); send(4'h0, 1'b0);
    check("pat_err3", err_cnt, 3);
    check("pat_fault0", fault, 0);
    send(4'h8, 1'b0);
    check("pat_m4_fault", fault, CONSEC ? 0 : 1);
    check("pat_m4_err", err_cnt, 4);
    send(4'h0, 1'b1); send(4'h3, 1'b0);
    check("pat_m6_fault", fault, CONSEC ? 0 : 1);
    check("pat_m6_err", err_cnt, CONSEC ? 6 : 4);
    send(4'h9, 1'b1);
    check("pat_end_fault", fault, 1);
    check("pat_end_err", err_cnt, CONSEC ? 7 : 4);
    check("pat_end_state", state, 2'b10);
    check("pat_syn", first_syn, 5'b00001);

    // Saturation on the narrow instance.
    en_s = 1'b1;
    step();
    valid_s = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("sat_sample", sample_cnt_s, 15);
    check("sat_err", err_cnt_s, 0);
    check("sat_state", state_s, 2'b01);
    step();
    check("sat_hold", sample_cnt_s, 15);
    valid_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
